// File: rtl/inferno_loader_pkg.sv
// Shared types for the williams2 ROM loader: FSM states, ROM region tags and
// the width of the core-side download address.
package inferno_loader_pkg;
  localparam int DN_ADDR_W = 18;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  typedef logic [1:0] region_t;
  localparam region_t RGN_PROG = 2'd0;
  localparam region_t RGN_GFX  = 2'd1;
  localparam region_t RGN_SND  = 2'd2;
  localparam region_t RGN_NONE = 2'd3;
endpackage

// File: rtl/inferno_rom_loader_if.sv
// HPS download strobes in, registered core dn_* write port out.
interface inferno_rom_loader_if;
  import inferno_loader_pkg::*;

  logic                 ioctl_download;
  logic                 ioctl_wr;
  logic [24:0]          ioctl_addr;
  logic [7:0]           ioctl_dout;
  logic [15:0]          ioctl_index;
  logic [DN_ADDR_W-1:0] dn_addr;
  logic [7:0]           dn_data;
  logic                 dn_wr;
  region_t              dn_region;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  dn_addr, dn_data, dn_wr, dn_region
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output dn_addr, dn_data, dn_wr, dn_region
  );
endinterface

// File: rtl/inferno_region_decode.sv
// Maps a ROM byte address onto its region tag by comparing against the
// end-of-region boundaries.
module inferno_region_decode
  import inferno_loader_pkg::*;
#(
  parameter logic [DN_ADDR_W-1:0] PROG_END = 18'h10000,
  parameter logic [DN_ADDR_W-1:0] GFX_END  = 18'h28000,
  parameter logic [DN_ADDR_W-1:0] SND_END  = 18'h2C000
) (
  input  logic [DN_ADDR_W-1:0] addr,
  output region_t              region
);
  always_comb begin
    region = RGN_NONE;
    if (addr < PROG_END)     region = RGN_PROG;
    else if (addr < GFX_END) region = RGN_GFX;
    else if (addr < SND_END) region = RGN_SND;
  end
endmodule

// File: rtl/inferno_rom_loader.sv
// Filters HPS ROM bytes onto the williams2 download port, tracks length and
// checksum, and holds the core in reset until a full image has settled.
module inferno_rom_loader
  import inferno_loader_pkg::*;
#(
  parameter logic [DN_ADDR_W-1:0] IMAGE_SIZE  = 18'h2C000,
  parameter logic [DN_ADDR_W-1:0] PROG_END    = 18'h10000,
  parameter logic [DN_ADDR_W-1:0] GFX_END     = 18'h28000,
  parameter logic [DN_ADDR_W-1:0] SND_END     = 18'h2C000,
  parameter int                   HOLD_CYCLES = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  inferno_rom_loader_if.slave  bus,
  output logic                 core_reset,
  output logic                 load_done,
  output logic                 load_error,
  output logic [DN_ADDR_W-1:0] byte_count,
  output logic [15:0]          checksum
);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state, state_n;
  logic        active, active_q, rise;
  logic        dl_q, fall_det;
  logic        idx_ok, in_range, strobe, accept, ovf_hit, ovf;
  logic        start, fail, done;
  logic [15:0] hold_cnt;
  region_t     rgn;

  assign idx_ok   = (bus.ioctl_index == 16'd0);
  assign active   = bus.ioctl_download & idx_ok;
  assign rise     = active & ~active_q;
  // Full 25-bit compare so high-address aliases never reach the core.
  assign in_range = (bus.ioctl_addr < {7'd0, IMAGE_SIZE});
  assign strobe   = (state == LOAD) & bus.ioctl_wr & idx_ok;
  assign accept   = strobe & in_range;
  assign ovf_hit  = strobe & ~in_range;

  inferno_region_decode #(
    .PROG_END (PROG_END),
    .GFX_END  (GFX_END),
    .SND_END  (SND_END)
  ) u_rgn (
    .addr   (bus.ioctl_addr[DN_ADDR_W-1:0]),
    .region (rgn)
  );

  always_comb begin
    state_n = state;
    start   = 1'b0;
    fail    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE, RUN: if (rise) begin
        state_n = LOAD;
        start   = 1'b1;
      end
      // fall_det lags the strobe path by a cycle, so byte_count already
      // includes a strobe coincident with the download fall.
      LOAD: if (fall_det) begin
        if (byte_count == IMAGE_SIZE && !ovf) state_n = HOLD;
        else begin
          state_n = IDLE;
          fail    = 1'b1;
        end
      end
      HOLD: if (hold_cnt == HOLD_LAST) begin
        state_n = RUN;
        done    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      active_q      <= 1'b0;
      dl_q          <= 1'b0;
      fall_det      <= 1'b0;
      hold_cnt      <= 16'd0;
      ovf           <= 1'b0;
      core_reset    <= 1'b1;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      byte_count    <= '0;
      checksum      <= 16'd0;
      bus.dn_wr     <= 1'b0;
      bus.dn_addr   <= '0;
      bus.dn_data   <= 8'd0;
      bus.dn_region <= RGN_PROG;
    end else begin
      state      <= state_n;
      active_q   <= active;
      dl_q       <= bus.ioctl_download;
      fall_det   <= dl_q & ~bus.ioctl_download;
      hold_cnt   <= (state == HOLD) ? hold_cnt + 16'd1 : 16'd0;
      core_reset <= (state_n != RUN);
      bus.dn_wr  <= accept;
      if (accept) begin
        bus.dn_addr   <= bus.ioctl_addr[DN_ADDR_W-1:0];
        bus.dn_data   <= bus.ioctl_dout;
        bus.dn_region <= rgn;
      end
      if (start) begin
        byte_count <= '0;
        checksum   <= 16'd0;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        ovf        <= 1'b0;
      end else begin
        if (accept) begin
          if (byte_count != {DN_ADDR_W{1'b1}}) byte_count <= byte_count + 1'b1;
          checksum <= checksum + {8'd0, bus.ioctl_dout};
        end
        if (ovf_hit) ovf        <= 1'b1;
        if (fail)    load_error <= 1'b1;
        if (done)    load_done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inferno_rom_loader.sv
// Directed bench for the ROM loader, using a scaled-down image map so full
// loads stay short.
module tb_inferno_rom_loader;
  import inferno_loader_pkg::*;

  localparam logic [17:0] IMG  = 18'h2C0;
  localparam logic [17:0] PEND = 18'h100;
  localparam logic [17:0] GEND = 18'h280;
  localparam logic [17:0] SEND = 18'h2B0;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        core_reset, load_done, load_error;
  logic [17:0] byte_count;
  logic [15:0] checksum;
  int          checks   = 0;
  int          failures = 0;
  logic [1:0]  rgn_seen [0:1023];

  inferno_rom_loader_if bus();

  inferno_rom_loader #(
    .IMAGE_SIZE (IMG), .PROG_END (PEND), .GFX_END (GEND), .SND_END (SEND),
    .HOLD_CYCLES (16)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus.slave),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic drive_byte(input logic [24:0] a, input logic [7:0] d,
                            output logic w1, output logic [17:0] oa,
                            output logic [7:0] od, output logic [1:0] orr,
                            output logic w2);
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    w1 = bus.dn_wr; oa = bus.dn_addr; od = bus.dn_data; orr = bus.dn_region;
    @(negedge clk_sys);
    w2 = bus.dn_wr;
  endtask

  task automatic load_bytes(input int n, input logic [7:0] ofs,
                            output int pulses, output int bad);
    logic w1, w2; logic [17:0] oa; logic [7:0] od; logic [1:0] orr;
    logic [7:0] d;
    pulses = 0; bad = 0;
    for (int a = 0; a < n; a++) begin
      d = 8'(a) + ofs;
      drive_byte(25'(a), d, w1, oa, od, orr, w2);
      if (w1) pulses++;
      if (!w1 || oa != 18'(a) || od != d || w2) bad++;
      if (a < 1024) rgn_seen[a] = orr;
    end
  endtask

  task automatic start_dl(input logic [15:0] idx);
    @(negedge clk_sys);
    bus.ioctl_index = idx; bus.ioctl_download = 1'b1;
  endtask

  task automatic stop_dl();
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    wait_cycles(3);
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
    checks++; if (bus.dn_wr !== 1'b0 || bus.dn_addr !== 18'd0 || bus.dn_data !== 8'd0 || bus.dn_region !== 2'd0) begin
      failures++; $display("FAIL reset_dn got wr=%b addr=%h data=%h rgn=%0d exp all 0", bus.dn_wr, bus.dn_addr, bus.dn_data, bus.dn_region); end
    checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin failures++; $display("FAIL reset_flags got done=%b err=%b exp 0 0", load_done, load_error); end
    checks++; if (byte_count !== 18'd0 || checksum !== 16'd0) begin failures++; $display("FAIL reset_counts got cnt=%h sum=%h exp 0 0", byte_count, checksum); end
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    @(negedge clk_sys); reset = 1'b0;
  endtask

  task automatic test_full_load();
    int pulses, bad, lat;
    start_dl(16'd0);
    load_bytes(int'(IMG), 8'd0, pulses, bad);
    stop_dl();
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_sys);
      if (!core_reset) begin lat = k - 1; break; end
    end
    checks++; if (pulses != 704) begin failures++; $display("FAIL full_pulses got=%0d exp=704", pulses); end
    checks++; if (bad != 0) begin failures++; $display("FAIL full_dn_timing got=%0d bad bytes exp=0", bad); end
    checks++; if (byte_count !== 18'h2C0) begin failures++; $display("FAIL full_count got=%h exp=2c0", byte_count); end
    checks++; if (checksum !== 16'h46A0) begin failures++; $display("FAIL full_checksum got=%h exp=46a0", checksum); end
    checks++; if (lat != 17) begin failures++; $display("FAIL full_release_latency got=%0d exp=17", lat); end
    checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin failures++; $display("FAIL full_flags got done=%b err=%b exp 1 0", load_done, load_error); end
  endtask

  task automatic test_region_tags();
    logic [17:0] ra [6];
    logic [1:0]  re [6];
    ra = '{18'h0FF, 18'h100, 18'h27F, 18'h280, 18'h2AF, 18'h2B0};
    re = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rgn_seen[ra[i]] !== re[i]) begin
        failures++; $display("FAIL region_tag addr=%h got=%0d exp=%0d", ra[i], rgn_seen[ra[i]], re[i]);
      end
    end
  endtask

  task automatic test_other_index();
    logic w1, w2; logic [17:0] oa; logic [7:0] od; logic [1:0] orr;
    int seen = 0;
    start_dl(16'd1);
    for (int i = 0; i < 4; i++) begin
      drive_byte(25'(i), 8'hA5, w1, oa, od, orr, w2);
      if (w1 || w2) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL idx1_dn_wr got=%0d pulses exp=0", seen); end
    checks++; if (byte_count !== 18'h2C0 || checksum !== 16'h46A0) begin failures++; $display("FAIL idx1_counts got cnt=%h sum=%h exp 2c0 46a0", byte_count, checksum); end
    stop_dl();
    bus.ioctl_index = 16'd0;
    wait_cycles(3);
    checks++; if (core_reset !== 1'b0 || dut.state !== RUN) begin failures++; $display("FAIL idx1_run got core_reset=%b state=%0d exp 0 %0d", core_reset, dut.state, RUN); end
  endtask

  task automatic test_short_image();
    int pulses, bad;
    start_dl(16'd0);
    @(negedge clk_sys);
    checks++; if (core_reset !== 1'b1 || load_done !== 1'b0 || byte_count !== 18'd0) begin
      failures++; $display("FAIL restart got core_reset=%b done=%b cnt=%h exp 1 0 0", core_reset, load_done, byte_count); end
    load_bytes(16, 8'd3, pulses, bad);
    stop_dl();
    wait_cycles(4);
    checks++; if (load_error !== 1'b1 || core_reset !== 1'b1) begin failures++; $display("FAIL short_flags got err=%b core_reset=%b exp 1 1", load_error, core_reset); end
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL short_state got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (byte_count !== 18'h10 || checksum !== 16'h00A8) begin failures++; $display("FAIL short_counts got cnt=%h sum=%h exp 10 a8", byte_count, checksum); end
  endtask

  task automatic test_overflow();
    int pulses, bad;
    logic w1, w2, v1, v2; logic [17:0] oa; logic [7:0] od; logic [1:0] orr;
    start_dl(16'd0);
    load_bytes(int'(IMG), 8'd0, pulses, bad);
    drive_byte(25'h00002C0, 8'h55, w1, oa, od, orr, w2);
    drive_byte(25'h1000005, 8'h77, v1, oa, od, orr, v2);
    checks++; if (w1 !== 1'b0) begin failures++; $display("FAIL ovf_edge_dn_wr got=%b exp=0", w1); end
    checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL ovf_high_dn_wr got=%b exp=0", v1); end
    stop_dl();
    wait_cycles(25);
    checks++; if (byte_count !== 18'h2C0 || checksum !== 16'h46A0) begin failures++; $display("FAIL ovf_counts got cnt=%h sum=%h exp 2c0 46a0", byte_count, checksum); end
    checks++; if (load_error !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0) begin
      failures++; $display("FAIL ovf_flags got err=%b core_reset=%b done=%b exp 1 1 0", load_error, core_reset, load_done); end
  endtask

  task automatic test_reset_mid_load();
    int pulses, bad;
    start_dl(16'd0);
    load_bytes(100, 8'd0, pulses, bad);
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd100; bus.ioctl_dout = 8'h64;
    @(posedge clk_sys);
    #1 reset = 1'b1; bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
    #1;
    checks++; if (bus.dn_wr !== 1'b0) begin failures++; $display("FAIL midrst_dn_wr got=%b exp=0", bus.dn_wr); end
    checks++; if (byte_count !== 18'd0 || checksum !== 16'd0 || dut.state !== IDLE) begin
      failures++; $display("FAIL midrst_state got cnt=%h sum=%h state=%0d exp 0 0 %0d", byte_count, checksum, dut.state, IDLE); end
    @(negedge clk_sys); reset = 1'b0;
    start_dl(16'd0);
    load_bytes(int'(IMG), 8'd0, pulses, bad);
    stop_dl();
    wait_cycles(20);
    checks++; if (pulses != 704 || bad != 0) begin failures++; $display("FAIL reload_dn got pulses=%0d bad=%0d exp 704 0", pulses, bad); end
    checks++; if (load_done !== 1'b1 || core_reset !== 1'b0 || byte_count !== 18'h2C0) begin
      failures++; $display("FAIL reload_flags got done=%b core_reset=%b cnt=%h exp 1 0 2c0", load_done, core_reset, byte_count); end
  endtask

  initial begin
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0;
    bus.ioctl_dout = 8'd0; bus.ioctl_index = 16'd0;
    test_reset();
    test_full_load();
    test_region_tags();
    test_other_index();
    test_short_image();
    test_overflow();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
